logic_gates_bist: RTL and testbench

- Sequential built-in self-test engine for the two-input logic-gate block. It is the hardware counterpart of the gate testbench.
- Drives `a` and `b` through the full truth table (00, 01, 10, 11), waits a settle interval, samples the eight gate outputs and compares them against internally generated expected values.
- Reports pass/fail, which input combinations failed, and which gate outputs mismatched.
- Sits between a control/status register or top-level test pin and the logic-gate instance.

---
 rtl/logic_gates_bist.sv | 218 +++++++++++++++++++++
 tb/tb_logic_gates_bist.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_bist.sv
// -----------------------------------------------------------------------------
// logic_gates_bist
//   Built-in self-test engine for the two-input logic-gate block. A run walks
//   {a,b} through 00, 01, 10, 11 (optionally several sweeps), holds each
//   combination for SETTLE_CYCLES cycles, then samples the eight gate responses
//   and compares them with internally generated expected values.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           run request, only honoured while idle
//   a, b            stimulus driven into the gate block
//   and_out..xnor_out  gate responses fed back for checking
//   busy            high while a run is in progress
//   done            one-cycle pulse at the end of a run
//   pass            last run had no mismatch; held until the next accepted start
//   fail_vec[3:0]   bit i set if combination {a,b}=i mismatched in any sweep
//   err_mask[7:0]   sticky OR of mismatching outputs
//                   ([7]and [6]or [5]not_a [4]not_b [3]nand [2]nor [1]xor [0]xnor)
//   err_count[3:0]  mismatching samples (per vector), saturating at 15
// -----------------------------------------------------------------------------
module logic_gates_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       and_out,
   input  logic       or_out,
   input  logic       not_out_a,
   input  logic       not_out_b,
   input  logic       nand_out,
   input  logic       nor_out,
   input  logic       xor_out,
   input  logic       xnor_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [7:0] err_mask,
   output logic [3:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

   // Golden gate responses, packed in err_mask bit order.
   function automatic logic [7:0] expected_gates(input logic a_v, input logic b_v);
      return {a_v & b_v, a_v | b_v, ~a_v, ~b_v,
              ~(a_v & b_v), ~(a_v | b_v), a_v ^ b_v, ~(a_v ^ b_v)};
   endfunction

   state_t     state_r,      state_s;
   logic [1:0] idx_r,        idx_s;
   logic [3:0] pass_cnt_r,   pass_cnt_s;
   logic [3:0] settle_cnt_r, settle_cnt_s;
   logic       a_r,          a_s;
   logic       b_r,          b_s;
   logic       busy_r,       busy_s;
   logic       done_r,       done_s;
   logic       pass_r,       pass_s;
   logic [3:0] fail_vec_r,   fail_vec_s;
   logic [7:0] err_mask_r,   err_mask_s;
   logic [3:0] err_count_r,  err_count_s;

   logic [7:0] sample_s;
   logic [7:0] diff_s;
   logic [1:0] idx_inc_s;

   assign sample_s  = {and_out, or_out, not_out_a, not_out_b,
                       nand_out, nor_out, xor_out, xnor_out};
   assign diff_s    = sample_s ^ expected_gates(a_r, b_r);
   assign idx_inc_s = idx_r + 2'd1;

   // State and result registers; every output comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= 2'd0;
         pass_cnt_r   <= 4'd0;
         settle_cnt_r <= 4'd0;
         a_r          <= 1'b0;
         b_r          <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         fail_vec_r   <= 4'd0;
         err_mask_r   <= 8'd0;
         err_count_r  <= 4'd0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         pass_cnt_r   <= pass_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         a_r          <= a_s;
         b_r          <= b_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         pass_r       <= pass_s;
         fail_vec_r   <= fail_vec_s;
         err_mask_r   <= err_mask_s;
         err_count_r  <= err_count_s;
      end
   end

   // Next-state and next-output logic; everything holds unless a state changes it.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      pass_cnt_s   = pass_cnt_r;
      settle_cnt_s = settle_cnt_r;
      a_s          = a_r;
      b_s          = b_r;
      busy_s       = busy_r;
      done_s       = 1'b0;
      pass_s       = pass_r;
      fail_vec_s   = fail_vec_r;
      err_mask_s   = err_mask_r;
      err_count_s  = err_count_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               idx_s        = 2'd0;
               pass_cnt_s   = 4'd0;
               settle_cnt_s = 4'd0;
               a_s          = 1'b0;
               b_s          = 1'b0;
               busy_s       = 1'b1;
               pass_s       = 1'b0;
               fail_vec_s   = 4'd0;
               err_mask_s   = 8'd0;
               err_count_s  = 4'd0;
               state_s      = ST_SETTLE;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            settle_cnt_s = settle_cnt_r + 4'd1;
            if (settle_cnt_r == SETTLE_LAST) begin
               state_s = ST_CHECK;
            end else begin
               state_s = ST_SETTLE;
            end
         end

         ST_CHECK: begin
            // Record this vector's mismatches, counting the vector once.
            if (diff_s != 8'd0) begin
               err_mask_s        = err_mask_r | diff_s;
               fail_vec_s[idx_r] = 1'b1;
               if (err_count_r != 4'd15) begin
                  err_count_s = err_count_r + 4'd1;
               end else begin
                  err_count_s = err_count_r;
               end
            end else begin
               err_mask_s = err_mask_r;
            end

            if (idx_r != 2'd3) begin
               idx_s        = idx_inc_s;
               a_s          = idx_inc_s[1];
               b_s          = idx_inc_s[0];
               settle_cnt_s = 4'd0;
               state_s      = ST_SETTLE;
            end else if (pass_cnt_r < PASS_LAST) begin
               idx_s        = 2'd0;
               a_s          = 1'b0;
               b_s          = 1'b0;
               pass_cnt_s   = pass_cnt_r + 4'd1;
               settle_cnt_s = 4'd0;
               state_s      = ST_SETTLE;
            end else begin
               state_s = ST_FINISH;
            end
         end

         ST_FINISH: begin
            // err_count already includes the final vector's result here.
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_count_r == 4'd0);
            a_s     = 1'b0;
            b_s     = 1'b0;
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            a_s     = 1'b0;
            b_s     = 1'b0;
         end
      endcase
   end

   assign a         = a_r;
   assign b         = b_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_vec  = fail_vec_r;
   assign err_mask  = err_mask_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_logic_gates_bist.sv
// -----------------------------------------------------------------------------
// tb_logic_gates_bist
//   Three engine instances with different SETTLE_CYCLES/PASSES share one clock.
//   Each drives its own behavioural gate block whose outputs can be corrupted
//   per input combination through a flip table; expected results are derived
//   from that table.
// -----------------------------------------------------------------------------
module tb_logic_gates_bist;

   localparam int NI = 3;
   localparam int ST[NI] = '{2, 2, 1};
   localparam int PS[NI] = '{1, 2, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_s   [NI];
   logic       a_w       [NI];
   logic       b_w       [NI];
   logic       busy_w    [NI];
   logic       done_w    [NI];
   logic       pass_w    [NI];
   logic [3:0] fail_vec_w[NI];
   logic [7:0] err_mask_w[NI];
   logic [3:0] err_count_w[NI];
   logic [7:0] gate_w    [NI];
   logic [7:0] flip      [NI][4];

   int n_vec = 0;
   int n_err = 0;

   // Truth-table gate model from integer arithmetic.
   function automatic logic [7:0] ideal(input logic av, input logic bv);
      int x, y;
      x = int'(av);
      y = int'(bv);
      return {1'(x * y), 1'(x + y > 0), 1'(1 - x), 1'(1 - y),
              1'(1 - x * y), 1'(x + y == 0), 1'(x + y == 1), 1'(x + y != 1)};
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      assign gate_w[gi] = ideal(a_w[gi], b_w[gi]) ^ flip[gi][{a_w[gi], b_w[gi]}];

      logic_gates_bist #(.SETTLE_CYCLES(ST[gi]), .PASSES(PS[gi])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_s[gi]),
         .a         (a_w[gi]),
         .b         (b_w[gi]),
         .and_out   (gate_w[gi][7]),
         .or_out    (gate_w[gi][6]),
         .not_out_a (gate_w[gi][5]),
         .not_out_b (gate_w[gi][4]),
         .nand_out  (gate_w[gi][3]),
         .nor_out   (gate_w[gi][2]),
         .xor_out   (gate_w[gi][1]),
         .xnor_out  (gate_w[gi][0]),
         .busy      (busy_w[gi]),
         .done      (done_w[gi]),
         .pass      (pass_w[gi]),
         .fail_vec  (fail_vec_w[gi]),
         .err_mask  (err_mask_w[gi]),
         .err_count (err_count_w[gi])
      );
   end

   // One full run on instance inst; start stays high afterwards when hold=1,
   // and is re-pulsed at edges 3 and 7 when repulse=1.
   task automatic run_check(input int inst, input bit hold, input bit repulse, input string tag);
      int         s, p, n, ecnt;
      logic [3:0] efv;
      logic [7:0] emask;
      logic       epass;
      s = ST[inst];
      p = PS[inst];
      n = 4 * p * (s + 1);
      efv = 4'd0; emask = 8'd0; ecnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (flip[inst][c] != 8'd0) begin
            efv[c] = 1'b1;
            emask  = emask | flip[inst][c];
            ecnt   = ecnt + p;
         end
      end
      if (ecnt > 15) ecnt = 15;
      epass = (ecnt == 0);

      start_s[inst] = 1'b1;
      for (int k = 0; k <= n + 1; k++) begin
         @(negedge clk);
         if (!hold && k == 0) start_s[inst] = 1'b0;
         if (repulse) start_s[inst] = (k == 2 || k == 6);
         if (k == 0) begin
            n_vec++;
            if ({busy_w[inst], done_w[inst], pass_w[inst], fail_vec_w[inst], err_mask_w[inst], err_count_w[inst]}
                !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0}) begin
               n_err++;
               $display("FAIL %s start_clear: busy=%b done=%b pass=%b fv=%b em=%b ec=%0d, need busy=1 rest 0",
                        tag, busy_w[inst], done_w[inst], pass_w[inst], fail_vec_w[inst],
                        err_mask_w[inst], err_count_w[inst]);
            end
         end
         if (k < n) begin
            n_vec++;
            if ({a_w[inst], b_w[inst], busy_w[inst], done_w[inst]} !== {2'((k / (s + 1)) % 4), 2'b10}) begin
               n_err++;
               $display("FAIL %s seq k=%0d: ab=%b%b busy=%b done=%b, need ab=%0d busy=1 done=0",
                        tag, k, a_w[inst], b_w[inst], busy_w[inst], done_w[inst], (k / (s + 1)) % 4);
            end
         end
         if (k == n) begin
            n_vec++;
            if ({busy_w[inst], done_w[inst]} !== 2'b10) begin
               n_err++;
               $display("FAIL %s early_done: busy=%b done=%b, need 1 0", tag, busy_w[inst], done_w[inst]);
            end
         end
         if (k == n + 1) begin
            n_vec++;
            if ({done_w[inst], busy_w[inst], a_w[inst], b_w[inst], pass_w[inst],
                 fail_vec_w[inst], err_mask_w[inst], err_count_w[inst]}
                !== {4'b1000, epass, efv, emask, 4'(ecnt)}) begin
               n_err++;
               $display("FAIL %s result: done=%b busy=%b ab=%b%b pass=%b fv=%b em=%b ec=%0d, need done=1 pass=%b fv=%b em=%b ec=%0d",
                        tag, done_w[inst], busy_w[inst], a_w[inst], b_w[inst], pass_w[inst],
                        fail_vec_w[inst], err_mask_w[inst], err_count_w[inst], epass, efv, emask, ecnt);
            end
         end
      end
      if (!hold) begin
         repeat (2) begin
            @(negedge clk);
            n_vec++;
            if ({done_w[inst], busy_w[inst], pass_w[inst], fail_vec_w[inst], err_mask_w[inst], err_count_w[inst]}
                !== {2'b00, epass, efv, emask, 4'(ecnt)}) begin
               n_err++;
               $display("FAIL %s hold: done=%b busy=%b pass=%b fv=%b em=%b ec=%0d, need idle with held results",
                        tag, done_w[inst], busy_w[inst], pass_w[inst], fail_vec_w[inst],
                        err_mask_w[inst], err_count_w[inst]);
            end
         end
      end
   endtask

   task automatic clear_flips(input int inst);
      for (int c = 0; c < 4; c++) flip[inst][c] = 8'd0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NI; i++) begin
         n_vec++;
         if ({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], fail_vec_w[i], err_mask_w[i], err_count_w[i]} !== 20'd0) begin
            n_err++;
            $display("FAIL reset inst%0d: ab=%b%b busy=%b done=%b pass=%b fv=%b em=%b ec=%0d, need all 0",
                     i, a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], fail_vec_w[i], err_mask_w[i], err_count_w[i]);
         end
      end
   endtask

   task automatic test_clean();
      clear_flips(0);
      run_check(0, 1'b0, 1'b0, "clean");
   endtask

   task automatic test_xor_stuck();
      clear_flips(0);
      flip[0][1] = 8'b0000_0010;
      flip[0][2] = 8'b0000_0010;
      run_check(0, 1'b0, 1'b0, "xor_stuck0");
   endtask

   task automatic test_nand_as_and();
      for (int c = 0; c < 4; c++) flip[1][c] = 8'b0000_1000;
      run_check(1, 1'b0, 1'b0, "nand_as_and");
   endtask

   task automatic test_repulse();
      clear_flips(0);
      flip[0][3] = 8'b1000_0001;
      run_check(0, 1'b0, 1'b1, "repulse");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int inst;
         inst = r % 2;
         for (int c = 0; c < 4; c++) begin
            flip[inst][c] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
         end
         run_check(inst, 1'b0, 1'b0, "random");
      end
   endtask

   task automatic test_mid_reset();
      clear_flips(0);
      flip[0][0] = 8'b0100_0000;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], fail_vec_w[0], err_mask_w[0], err_count_w[0]} !== 20'd0) begin
         n_err++;
         $display("FAIL mid_reset: ab=%b%b busy=%b done=%b fv=%b em=%b ec=%0d, need all 0",
                  a_w[0], b_w[0], busy_w[0], done_w[0], fail_vec_w[0], err_mask_w[0], err_count_w[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         n_vec++;
         if ({done_w[0], busy_w[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_idle k=%0d: done=%b busy=%b, need 0 0", k, done_w[0], busy_w[0]);
         end
      end
      clear_flips(0);
      run_check(0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back();
      clear_flips(2);
      flip[2][2] = 8'b0010_0000;
      run_check(2, 1'b1, 1'b0, "b2b_run1");
      clear_flips(2);
      run_check(2, 1'b1, 1'b0, "b2b_run2");
      flip[2][1] = 8'($urandom) | 8'h01;
      run_check(2, 1'b0, 1'b0, "b2b_run3");
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b0;
         clear_flips(i);
      end
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean();
      test_xor_stuck();
      test_nand_as_and();
      test_repulse();
      test_random();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
